// File: rtl/peak_pkg.sv
// Shared constants for the FFT peak detector.
// Optional spectrum RAM is enabled with PEAK_SPEC_RAM_EN.
package peak_pkg;

    localparam int DEF_TRUNC_W = 16;
    localparam int DEF_CNT_W   = 10;
    localparam int POW_W       = 2*DEF_TRUNC_W+1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FRAME  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

endpackage

// File: rtl/fft_power_calc.sv
// Two-stage power pipeline: truncate and square, then sum.
// Valid, bin and eop tags travel alongside the data.
module fft_power_calc
    import peak_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TRUNC_W = DEF_TRUNC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 beat_valid,
    input  logic                 beat_eop,
    input  logic [CNT_W-1:0]     beat_bin,
    input  logic [DATA_W-1:0]    beat_real,
    input  logic [DATA_W-1:0]    beat_imag,
    output logic                 pow_valid,
    output logic                 pow_eop,
    output logic [CNT_W-1:0]     pow_bin,
    output logic [2*TRUNC_W:0]   power
);

    localparam int SQ_W = 2*TRUNC_W;

    logic signed [TRUNC_W-1:0] re_t;
    logic signed [TRUNC_W-1:0] im_t;
    logic signed [SQ_W-1:0]    re_x;
    logic signed [SQ_W-1:0]    im_x;
    logic                      unused_lsb;

    logic                      s1_valid;
    logic                      s1_eop;
    logic [CNT_W-1:0]          s1_bin;
    logic [SQ_W-1:0]           s1_re2;
    logic [SQ_W-1:0]           s1_im2;

    assign re_t = beat_real[DATA_W-1 -: TRUNC_W];
    assign im_t = beat_imag[DATA_W-1 -: TRUNC_W];
    assign re_x = {{TRUNC_W{re_t[TRUNC_W-1]}}, re_t};
    assign im_x = {{TRUNC_W{im_t[TRUNC_W-1]}}, im_t};
    assign unused_lsb = ^{beat_real[DATA_W-TRUNC_W-1:0],
                          beat_imag[DATA_W-TRUNC_W-1:0]};

    // Stage 1: squares of the truncated components plus tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_eop   <= 1'b0;
            s1_bin   <= '0;
            s1_re2   <= '0;
            s1_im2   <= '0;
        end else begin
            s1_valid <= beat_valid;
            s1_eop   <= beat_valid & beat_eop;
            s1_bin   <= beat_bin;
            s1_re2   <= re_x * re_x;
            s1_im2   <= im_x * im_x;
        end
    end

    // Stage 2: power sum, one extra bit so it never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pow_valid <= 1'b0;
            pow_eop   <= 1'b0;
            pow_bin   <= '0;
            power     <= '0;
        end else begin
            pow_valid <= s1_valid;
            pow_eop   <= s1_valid & s1_eop;
            pow_bin   <= s1_bin;
            power     <= {1'b0, s1_re2} + {1'b0, s1_im2};
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame FFT peak finder with framing error detection.
// PEAK_SPEC_RAM_EN adds a readable per-bin power RAM.
module fft_peak_detect
    import peak_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TRUNC_W = DEF_TRUNC_W,
    parameter int FFT_N   = 1024,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int SKIP_DC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fft_out_valid,
    input  logic                 fft_out_sop,
    input  logic                 fft_out_eop,
    input  logic [DATA_W-1:0]    fft_out_real,
    input  logic [DATA_W-1:0]    fft_out_imag,
    output logic                 peak_valid,
    output logic [CNT_W-1:0]     peak_bin,
    output logic [2*TRUNC_W:0]   peak_power,
    output logic [15:0]          frame_cnt,
    output logic                 err_sop,
    output logic                 err_len
`ifdef PEAK_SPEC_RAM_EN
    ,
    input  logic [CNT_W-1:0]     spec_rd_addr,
    output logic [2*TRUNC_W:0]   spec_rd_data
`endif
);

    localparam int PW = 2*TRUNC_W+1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_N-1);

    logic [1:0]       state;
    logic [1:0]       cstate;
    logic [CNT_W-1:0] bin_cnt;
    logic [CNT_W-1:0] idx;
    logic             in_frame;
    logic             restart;
    logic             acc;
    logic             over;
    logic             eop_hit;
    logic             good_eop;
    logic             e_len;
    logic             e_sop;
    logic             tag_valid;

    logic             pow_valid;
    logic             pow_eop;
    logic [CNT_W-1:0] pow_bin;
    logic [PW-1:0]    power;
    logic [PW-1:0]    max_pow;
    logic [CNT_W-1:0] max_bin;

    // Classify the incoming beat against the current frame.
    always_comb begin
        in_frame  = (state == S_FRAME);
        restart   = fft_out_valid & fft_out_sop;
        acc       = fft_out_valid & (fft_out_sop | in_frame);
        over      = fft_out_valid & ~fft_out_sop & in_frame
                    & (bin_cnt == LAST);
        idx       = restart ? '0 : bin_cnt + 1'b1;
        eop_hit   = acc & fft_out_eop;
        good_eop  = eop_hit & ~over & (idx == LAST);
        e_len     = over | (eop_hit & ~good_eop);
        e_sop     = restart & in_frame & ~e_len;
        tag_valid = acc & ~e_len;
    end

    // Framing FSM: bin counter and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bin_cnt <= '0;
            err_sop <= 1'b0;
            err_len <= 1'b0;
        end else begin
            err_sop <= e_sop;
            err_len <= e_len;
            if (acc) bin_cnt <= idx;
            if (e_len | good_eop) state <= S_IDLE;
            else if (acc) state <= S_FRAME;
        end
    end

    fft_power_calc #(
        .DATA_W  (DATA_W),
        .TRUNC_W (TRUNC_W),
        .CNT_W   (CNT_W)
    ) u_pow (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_valid (tag_valid),
        .beat_eop   (good_eop),
        .beat_bin   (idx),
        .beat_real  (fft_out_real),
        .beat_imag  (fft_out_imag),
        .pow_valid  (pow_valid),
        .pow_eop    (pow_eop),
        .pow_bin    (pow_bin),
        .power      (power)
    );

    // Max tracker: bin 0 starts a new frame; strict compare keeps lower bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_pow <= '0;
            max_bin <= '0;
            cstate  <= S_IDLE;
        end else begin
            cstate <= (pow_valid & pow_eop) ? S_REPORT : S_IDLE;
            if (pow_valid) begin
                if (pow_bin == '0) begin
                    max_bin <= '0;
                    max_pow <= (SKIP_DC != 0) ? '0 : power;
                end else if (power > max_pow) begin
                    max_bin <= pow_bin;
                    max_pow <= power;
                end
            end
        end
    end

    // Report cycle: publish the finished frame's peak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_power <= '0;
            frame_cnt  <= '0;
        end else begin
            peak_valid <= (cstate == S_REPORT);
            if (cstate == S_REPORT) begin
                peak_bin   <= max_bin;
                peak_power <= max_pow;
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef PEAK_SPEC_RAM_EN
    logic [PW-1:0] mem [FFT_N];

    // Spectrum RAM write port: every tracked bin's power.
    always_ff @(posedge clk) begin
        if (pow_valid) mem[pow_bin] <= power;
    end

    // Registered read port; read-during-write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spec_rd_data <= '0;
        else        spec_rd_data <= mem[spec_rd_addr];
    end
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect (SKIP_DC=1 and SKIP_DC=0 copies).
// Build with PEAK_SPEC_RAM_EN to also exercise the spectrum RAM.
module tb_fft_peak_detect;

    typedef struct {
        int     bin;
        longint pow;
        int     fc;
        int     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v, sop, eop;
    logic [31:0] re_in, im_in;

    logic        pv1, es1, el1, pv0, es0, el0;
    logic [9:0]  pb1, pb0;
    logic [32:0] pp1, pp0;
    logic [15:0] fc1, fc0;
`ifdef PEAK_SPEC_RAM_EN
    logic [9:0]  ra;
    logic [32:0] rd1, rd0;
`endif

    logic [31:0] re_v [1024];
    logic [31:0] im_v [1024];

    exp_t q1[$];
    exp_t q0[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_sop = 0;
    int   n_len = 0;
    int   exp_fc = 0;
    int   s0, l0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fft_peak_detect #(.SKIP_DC(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fft_out_valid(v), .fft_out_sop(sop), .fft_out_eop(eop),
        .fft_out_real(re_in), .fft_out_imag(im_in),
        .peak_valid(pv1), .peak_bin(pb1), .peak_power(pp1),
        .frame_cnt(fc1), .err_sop(es1), .err_len(el1)
`ifdef PEAK_SPEC_RAM_EN
        , .spec_rd_addr(ra), .spec_rd_data(rd1)
`endif
    );

    fft_peak_detect #(.SKIP_DC(0)) u_dut_dc (
        .clk(clk), .rst_n(rst_n),
        .fft_out_valid(v), .fft_out_sop(sop), .fft_out_eop(eop),
        .fft_out_real(re_in), .fft_out_imag(im_in),
        .peak_valid(pv0), .peak_bin(pb0), .peak_power(pp0),
        .frame_cnt(fc0), .err_sop(es0), .err_len(el0)
`ifdef PEAK_SPEC_RAM_EN
        , .spec_rd_addr(ra), .spec_rd_data(rd0)
`endif
    );

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Monitor: pop and compare whenever a DUT reports a peak.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (es1) n_sop++;
            if (el1) n_len++;
            if (pv1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_peak_skipdc", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("peak_bin_skipdc", pb1, e.bin);
                    chk("peak_pow_skipdc", pp1, e.pow);
                    chk("frame_cnt_skipdc", fc1, e.fc);
                    chk("latency_skipdc", cyc, e.cyc);
                end
            end
            if (pv0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_peak_dc", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("peak_bin_dc", pb0, e.bin);
                    chk("peak_pow_dc", pp0, e.pow);
                    chk("frame_cnt_dc", fc0, e.fc);
                    chk("latency_dc", cyc, e.cyc);
                end
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < 1024; i++) begin
            re_v[i] = '0;
            im_v[i] = '0;
        end
    endtask

    task automatic beat(input bit s, input bit e, input logic [31:0] r,
                        input logic [31:0] m);
        @(posedge clk);
        #1;
        v = 1'b1;
        sop = s;
        eop = e;
        re_in = r;
        im_in = m;
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
        v = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) gap();
    endtask

    // Sends n beats; a good frame pushes its expected report
    // (due 4 counted edges after the eop beat is driven).
    task automatic send_frame(input int n, input int gp, input bit use_eop,
                              input bit good, input int b1, input longint p1,
                              input int b0, input longint p0);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gp > 0 && $urandom_range(99) < gp) gap();
            beat(i == 0, use_eop && i == n-1, re_v[i], im_v[i]);
        end
        if (use_eop && good) begin
            exp_fc++;
            q1.push_back('{b1, p1, exp_fc, cyc+4});
            q0.push_back('{b0, p0, exp_fc, cyc+4});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v = 1'b0; sop = 1'b0; eop = 1'b0;
        re_in = '0; im_in = '0;
`ifdef PEAK_SPEC_RAM_EN
        ra = '0;
`endif
        clr();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_peak_valid", pv1, 0);
        chk("reset_peak_bin", pb1, 0);
        chk("reset_peak_power", pp1, 0);
        chk("reset_frame_cnt", fc1, 0);
        chk("reset_err_sop", es1, 0);
        chk("reset_err_len", el1, 0);
`ifdef PEAK_SPEC_RAM_EN
        chk("reset_spec_rd_data", rd1, 0);
`endif

        // Single tone at bin 100: 100^2.
        clr();
        re_v[100] = 32'h0064_0000;
        send_frame(1024, 0, 1, 1, 100, 10000, 100, 10000);
        gap();
        idle(6);
        chk("frame_cnt_after_tone", fc1, 1);
`ifdef PEAK_SPEC_RAM_EN
        ra = 10'd100;
        @(posedge clk); #1;
        chk("ram_bin100", rd1, 10000);
        ra = 10'd101;
        @(posedge clk); #1;
        chk("ram_bin101", rd1, 0);
`endif

        // DC plus tie between bins 5 and 9.
        clr();
        re_v[0] = 32'h7FFF_0000;
        im_v[5] = 32'h0003_0000;
        im_v[9] = 32'h0003_0000;
        send_frame(1024, 0, 1, 1, 5, 9, 0, 64'd1073676289);
        gap();
        idle(6);

        // Early eop at bin 511.
        s0 = n_sop; l0 = n_len;
        clr();
        re_v[20] = 32'h0010_0000;
        send_frame(512, 0, 1, 0, 0, 0, 0, 0);
        gap();
        idle(6);
        chk("short_frame_err_len", n_len - l0, 1);
        chk("short_frame_err_sop", n_sop - s0, 0);
        chk("short_frame_frame_cnt", fc1, exp_fc);

        // sop at bin 300 then a good frame.
        s0 = n_sop; l0 = n_len;
        clr();
        im_v[333] = 32'hFFF6_0000;
        send_frame(300, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1024, 0, 1, 1, 333, 100, 333, 100);
        gap();
        idle(6);
        chk("restart_err_sop", n_sop - s0, 1);
        chk("restart_err_len", n_len - l0, 0);

        // Back-to-back frames with random valid gaps.
        s0 = n_sop; l0 = n_len;
        clr();
        re_v[7] = 32'h0005_0000;
        send_frame(1024, 30, 1, 1, 7, 25, 7, 25);
        clr();
        re_v[900] = 32'h0002_0000;
        im_v[900] = 32'h0003_0000;
        send_frame(1024, 30, 1, 1, 900, 13, 900, 13);
        gap();
        idle(6);
        chk("b2b_frame_cnt", fc1, exp_fc);
        chk("b2b_errors", (n_sop - s0) + (n_len - l0), 0);

        // Reset in the middle of a frame.
        clr();
        re_v[50] = 32'h0010_0000;
        send_frame(401, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_peak_valid", pv1, 0);
        chk("midrst_peak_bin", pb1, 0);
        chk("midrst_peak_power", pp1, 0);
        chk("midrst_frame_cnt", fc1, 0);
        chk("midrst_frame_cnt_dc", fc0, 0);
        v = 1'b0; sop = 1'b0; eop = 1'b0;
        exp_fc = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        re_v[200] = 32'h0001_0000;
        im_v[200] = 32'h0001_0000;
        send_frame(1024, 0, 1, 1, 200, 2, 200, 2);
        gap();
        idle(6);
        chk("post_reset_frame_cnt", fc1, 1);

        idle(4);
        chk("queue_drained_skipdc", q1.size(), 0);
        chk("queue_drained_dc", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Consumes the FFT core's Avalon-ST output stream (valid/sop/eop, real/imag) directly downstream of the FFT in the DDS->FIR->FIFO->FFT chain.
- Computes per-bin power, tracks the strongest bin per frame, and reports bin index and power once per complete frame.
- Flags framing errors (early sop, wrong frame length).
- Always ready: no backpressure is offered to the FFT.

Parameters:
- DATA_W, 32, width of fft_out_real / fft_out_imag (signed two's complement)
- TRUNC_W, 16, MSBs of each component kept for squaring
- FFT_N, 1024, points per frame
- CNT_W, 10, bin index width (2^CNT_W == FFT_N)
- SKIP_DC, 1, 1 = bin 0 excluded from peak search

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- fft_out_valid, in, 1, beat valid
- fft_out_sop, in, 1, first bin of frame (qualified by valid)
- fft_out_eop, in, 1, last bin of frame (qualified by valid)
- fft_out_real, in, DATA_W, real part
- fft_out_imag, in, DATA_W, imaginary part
- peak_valid, out, 1, one-cycle pulse: peak_bin/peak_power updated
- peak_bin, out, CNT_W, index of max-power bin of last good frame
- peak_power, out, 2*TRUNC_W+1, power of that bin
- frame_cnt, out, 16, count of good frames, wraps 0xFFFF->0
- err_sop, out, 1, one-cycle pulse: sop received mid-frame
- err_len, out, 1, one-cycle pulse: eop at wrong bin count, or frame overran FFT_N

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal counters, max registers and pipeline valids cleared. Reset asserted mid-frame discards the frame and emits no pulse.
- Truncation: re_t = real[DATA_W-1 -: TRUNC_W], im_t likewise (signed).
- Stage 1 (registered): re_t*re_t and im_t*im_t as unsigned 2*TRUNC_W values, plus bin index and eop tag.
- Stage 2 (registered): power = sum, 2*TRUNC_W+1 bits, no saturation needed.
- FSM states: IDLE, FRAME, REPORT.
- IDLE:
  - valid & sop: bin_cnt=0, max_pow=0, max_bin=0, go to FRAME; the beat is processed.
  - valid without sop: ignored, no error.
- FRAME:
  - Each valid beat increments bin_cnt.
  - valid & sop: err_sop pulse; frame restarts at this beat as bin 0; stays in FRAME.
  - valid & eop with bin_cnt == FFT_N-1: go to REPORT once that beat leaves stage 2.
  - valid & eop with any other bin_cnt: err_len pulse; frame discarded; go to IDLE.
  - bin_cnt reaches FFT_N-1 without eop, and a further valid beat arrives without sop: err_len pulse; go to IDLE.
  - sop and eop on the same beat in FRAME: treated as sop (restart), then as eop at bin 0, giving err_len. Only one error pulse per cycle is allowed; err_len takes priority.
- Peak compare (on stage-2 output):
  - If power > max_pow (strict), update max_pow and max_bin. Ties keep the lower bin.
  - Bin 0 is skipped when SKIP_DC=1.
- REPORT (one cycle):
  - peak_bin <= max_bin, peak_power <= max_pow, peak_valid=1, frame_cnt++, go to IDLE.
- Latency: peak_valid rises exactly 3 cycles after the clock edge sampling the eop beat (2 pipeline stages + REPORT).
- Back-to-back frames: sop may arrive in the cycle after eop. The pipeline drains independently, with a separate max-tracker commit, so the new frame is accepted with no gap.
- Gaps: valid may deassert any cycle mid-frame; pipeline tags carry validity.

Optional Feature:
- Macro PEAK_SPEC_RAM_EN.
- Defined:
  - Adds ports spec_rd_addr (in, CNT_W) and spec_rd_data (out, 2*TRUNC_W+1).
  - An FFT_N-deep simple dual-port RAM is written with each bin's stage-2 power at its bin index.
  - Synchronous read, 1-cycle latency; spec_rd_data resets to 0.
  - A read during a write to the same address returns the old data.
  - Contents after a bad frame are undefined.
- Undefined: no RAM and no extra ports.

Decomposition:
- Package peak_pkg: FSM state encoding (IDLE/FRAME/REPORT), TRUNC_W/CNT_W defaults, POW_W = 2*TRUNC_W+1 constant.
- One sub-module, fft_power_calc: the 2-stage truncate/square/sum pipeline carrying valid, bin and eop tags.

Test Plan:
- Single tone: frame of 1024 beats, all zero except bin 100 with real=0x00640000, imag=0 -> 3 cycles after eop: peak_valid=1, peak_bin=100, peak_power=10000, frame_cnt=1.
- DC + tie:
  - Bin 0 real=0x7FFF0000, bins 5 and 9 imag=0x00030000, rest 0, SKIP_DC=1 -> peak_bin=5, peak_power=9.
  - Same frame with SKIP_DC=0 -> peak_bin=0, peak_power=1073676289.
- Framing errors:
  - eop at bin 511 -> err_len pulse, no peak_valid, frame_cnt unchanged.
  - sop at bin 300 followed by 1024 good beats -> err_sop once, then normal report.
- Back-to-back with gaps: two frames, sop one cycle after eop, with random valid deassertion (tones at bins 7 and 900) -> two peak_valid pulses reporting 7 then 900, frame_cnt=2.
- Reset mid-frame: rst_n low at bin 400 -> all outputs 0 immediately; the next full frame reports correctly.
- PEAK_SPEC_RAM_EN: after the single-tone frame, read addr 100 -> 10000 one cycle later; addr 101 -> 0.
